// File: rtl/cmp_pkg.sv
// Shared types for the compare sequencer: default width, FSM states and
// the registered lt/eq/gt flag bundle.
package cmp_pkg;

    localparam int CMP_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_A  = 2'd1,
        COMPARE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } flags_t;

    localparam flags_t FLAGS_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

endpackage

// File: rtl/btn_edge.sv
// One-cycle rising-edge pulse generator for an already-synchronised button.
// History resets to 1 so a button held through reset does not fire.
module btn_edge (
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic pulse
);

    logic inPrev;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            inPrev <= 1'b1;
        end else begin
            inPrev <= in;
        end
    end

    assign pulse = in & ~inPrev;

endmodule

// File: rtl/compare_sequencer.sv
// Sequential front end for the subtract/compare datapath: loads A then B from
// the switches, samples the external subtractor for one cycle, holds the result.
module compare_sequencer
    import cmp_pkg::*;
#(
    parameter int WIDTH      = CMP_WIDTH,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] sw,
    input  logic             loadBtn,
    input  logic             clearBtn,
    input  logic [WIDTH-1:0] subZ,
    input  logic             subCOut,
    input  logic             subOverflow,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic             haveA,
    output logic             valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] diff
);

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] opANext;
    logic [WIDTH-1:0] opBNext;
    logic [WIDTH-1:0] diffNext;
    flags_t           flags;
    flags_t           flagsNext;
    flags_t           cmpFlags;
    logic             loadEdge;
    logic             ltRaw;

    btn_edge uLoadEdge (
        .clk    (clk),
        .resetN (resetN),
        .in     (loadBtn),
        .pulse  (loadEdge)
    );

    // lt is masked by eq so exactly one flag is set even if the subtractor glitches
    always_comb begin
        ltRaw       = SIGNED_CMP ? (subZ[WIDTH-1] ^ subOverflow) : ~subCOut;
        cmpFlags.eq = (subZ == '0);
        cmpFlags.lt = ltRaw & ~cmpFlags.eq;
        cmpFlags.gt = ~cmpFlags.lt & ~cmpFlags.eq;
    end

    always_comb begin
        stateNext = state;
        opANext   = opA;
        opBNext   = opB;
        diffNext  = diff;
        flagsNext = flags;

        if (clearBtn) begin
            stateNext = IDLE;
            opANext   = '0;
            opBNext   = '0;
            diffNext  = '0;
            flagsNext = FLAGS_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (loadEdge) begin
                        opANext   = sw;
                        stateNext = HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (loadEdge) begin
                        opBNext   = sw;
                        stateNext = COMPARE;
                    end
                end
                COMPARE: begin
                    diffNext  = subZ;
                    flagsNext = cmpFlags;
                    stateNext = RESULT;
                end
                RESULT: begin
                    // A new press starts the next comparison straight from operand A
                    if (loadEdge) begin
                        opANext   = sw;
                        opBNext   = '0;
                        diffNext  = '0;
                        flagsNext = FLAGS_NONE;
                        stateNext = HAVE_A;
                    end
                end
                default: begin
                    opANext   = '0;
                    opBNext   = '0;
                    diffNext  = '0;
                    flagsNext = FLAGS_NONE;
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
            opA   <= '0;
            opB   <= '0;
            diff  <= '0;
            flags <= FLAGS_NONE;
        end else begin
            state <= stateNext;
            opA   <= opANext;
            opB   <= opBNext;
            diff  <= diffNext;
            flags <= flagsNext;
        end
    end

    assign haveA = (state == HAVE_A);
    assign valid = (state == RESULT);
    assign lt    = flags.lt;
    assign eq    = flags.eq;
    assign gt    = flags.gt;

endmodule
